// File: rtl/m_mem_master_pkg.sv
// Shared encodings for the M-stage memory master: memory op codes, FSM states,
// byte-enable constants and small op-classification helpers.
package m_mem_master_pkg;

    localparam logic [2:0] MEMOP_LB  = 3'd0;
    localparam logic [2:0] MEMOP_LBU = 3'd1;
    localparam logic [2:0] MEMOP_LH  = 3'd2;
    localparam logic [2:0] MEMOP_LHU = 3'd3;
    localparam logic [2:0] MEMOP_LW  = 3'd4;
    localparam logic [2:0] MEMOP_SB  = 3'd5;
    localparam logic [2:0] MEMOP_SH  = 3'd6;
    localparam logic [2:0] MEMOP_SW  = 3'd7;

    typedef enum logic [1:0] {
        MM_IDLE = 2'd0,
        MM_REQ  = 2'd1,
        MM_RESP = 2'd2
    } mm_state_e;

    localparam logic [3:0] BE_B0      = 4'b0001;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_ALL     = 4'b1111;

    function automatic logic is_load(input logic [2:0] op);
        return op <= MEMOP_LW;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lo);
        case (op)
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: return lo[0];
            MEMOP_LW, MEMOP_SW:            return lo != 2'b00;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/m_mem_master_lane.sv
// m_mem_lane: combinational byte-lane logic shared by memory masters --
// store byte enables / lane replication and load byte/half extraction with extension.
module m_mem_lane
    import m_mem_master_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rword_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = rword_i[{addr_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        be_o    = BE_ALL;
        wdata_o = wdata_i;
        rdata_o = rword_i;
        case (op_i)
            MEMOP_LB:  rdata_o = {{24{byte_sel[7]}}, byte_sel};
            MEMOP_LBU: rdata_o = {24'h0, byte_sel};
            MEMOP_LH:  rdata_o = {{16{half_sel[15]}}, half_sel};
            MEMOP_LHU: rdata_o = {16'h0, half_sel};
            MEMOP_SB: begin
                be_o    = BE_B0 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            MEMOP_SH: begin
                be_o    = addr_lo_i[1] ? BE_HI_HALF : BE_LO_HALF;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/m_mem_master.sv
// M-stage load/store initiator on a req/ack data bus with request timeout.
// Build option ALIGN_EXC_EN: misaligned half/word accesses raise exc_adel/exc_ades without bus activity.
module m_mem_master
    import m_mem_master_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        bus_err_o,
    output logic        exc_adel_o,
    output logic        exc_ades_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    mm_state_e   state_q;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        rdata_valid_q;
    logic        err_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;
    logic        in_req;

    m_mem_lane u_lane (
        .op_i      (op_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rword_i   (bus_rdata_i),
        .be_o      (lane_be),
        .wdata_o   (lane_wdata),
        .rdata_o   (lane_rdata)
    );

`ifdef ALIGN_EXC_EN
    logic adel_q;
    logic ades_q;
    assign exc_adel_o = adel_q;
    assign exc_ades_o = ades_q;
`else
    assign exc_adel_o = 1'b0;
    assign exc_ades_o = 1'b0;
`endif

    // Response registers default to 0 so they only show a value during the single RESP cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= MM_IDLE;
            op_q          <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
            cnt_q         <= '0;
`ifdef ALIGN_EXC_EN
            adel_q        <= 1'b0;
            ades_q        <= 1'b0;
`endif
        end else begin
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
`ifdef ALIGN_EXC_EN
            adel_q        <= 1'b0;
            ades_q        <= 1'b0;
`endif
            case (state_q)
                MM_IDLE: begin
                    if (op_valid_i) begin
                        op_q    <= op_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        cnt_q   <= '0;
`ifdef ALIGN_EXC_EN
                        if (is_misaligned(op_i, addr_i[1:0])) begin
                            state_q <= MM_RESP;
                            adel_q  <= is_load(op_i);
                            ades_q  <= ~is_load(op_i);
                        end else
`endif
                        state_q <= MM_REQ;
                    end
                end
                MM_REQ: begin
                    if (bus_ack_i) begin
                        state_q       <= MM_RESP;
                        rdata_valid_q <= is_load(op_q);
                        rdata_q       <= is_load(op_q) ? lane_rdata : '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q       <= MM_RESP;
                        rdata_valid_q <= is_load(op_q);
                        err_q         <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                MM_RESP: state_q <= MM_IDLE;
                default: state_q <= MM_IDLE;
            endcase
        end
    end

    assign in_req        = (state_q == MM_REQ);
    assign stall_o       = in_req | ((state_q == MM_IDLE) & op_valid_i);
    assign bus_req_o     = in_req;
    assign bus_we_o      = in_req & ~is_load(op_q);
    assign bus_addr_o    = in_req ? {addr_q[31:2], 2'b00} : '0;
    assign bus_be_o      = in_req ? lane_be : '0;
    assign bus_wdata_o   = in_req ? lane_wdata : '0;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign bus_err_o     = err_q;

endmodule

// File: tb/tb_m_mem_master.sv
// Directed bench for m_mem_master (default build): vector table of ops plus
// hand sequences for timeout, ack-in-last-cycle and reset during a request.
module tb_m_mem_master;
    import m_mem_master_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid_i;
    logic [2:0]  op_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        bus_err_o;
    logic        exc_adel_o;
    logic        exc_ades_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    int n_checks = 0;
    int n_fail   = 0;

    m_mem_master #(.TIMEOUT_CYC(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .op_valid_i    (op_valid_i),
        .op_i          (op_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .stall_o       (stall_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .bus_err_o     (bus_err_o),
        .exc_adel_o    (exc_adel_o),
        .exc_ades_o    (exc_ades_o),
        .bus_req_o     (bus_req_o),
        .bus_we_o      (bus_we_o),
        .bus_addr_o    (bus_addr_o),
        .bus_be_o      (bus_be_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_ack_i     (bus_ack_i),
        .bus_rdata_i   (bus_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rword;
        int          d;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_we;
        logic [31:0] e_rdata;
        logic        e_rv;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s actual=%h expected=%h", tag, what, act, exp);
        end
    endtask

    // d = REQ cycles before the ack cycle; d >= TO means no ack (timeout).
    task automatic run_op(input string tag, input vec_t v, input logic e_err, input logic chk_rv);
        int req_cyc;
        int stall_cyc;
        int last;
        req_cyc   = 0;
        stall_cyc = 0;
        last      = (v.d < TO) ? v.d : TO - 1;
        @(negedge clk);
        op_valid_i = 1'b1;
        op_i       = v.op;
        addr_i     = v.addr;
        wdata_i    = v.wdata;
        #1;
        chk(tag, "stall_idle", stall_o, 1);
        chk(tag, "req_idle", bus_req_o, 0);
        if (stall_o) stall_cyc++;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            if (k == 0) begin
                op_valid_i = 1'b0;
                addr_i     = 32'hFFFF_FFFF;
                wdata_i    = 32'h0;
            end
            #1;
            if (bus_req_o) req_cyc++;
            if (stall_o) stall_cyc++;
            if (k == last) begin
                chk(tag, "bus_addr", bus_addr_o, v.e_addr);
                chk(tag, "bus_be", {28'h0, bus_be_o}, {28'h0, v.e_be});
                chk(tag, "bus_wdata", bus_wdata_o, v.e_wdata);
                chk(tag, "bus_we", bus_we_o, v.e_we);
            end
            if (k == v.d) begin
                bus_ack_i   = 1'b1;
                bus_rdata_i = v.rword;
            end
        end
        @(negedge clk);
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'h5A5A_C3C3;
        #1;
        chk(tag, "req_cycles", req_cyc, last + 1);
        chk(tag, "stall_cycles", stall_cyc, last + 2);
        chk(tag, "resp_req", bus_req_o, 0);
        chk(tag, "resp_stall", stall_o, 0);
        chk(tag, "resp_rdata", rdata_o, v.e_rdata);
        chk(tag, "resp_err", bus_err_o, e_err);
        if (chk_rv) chk(tag, "resp_rvalid", rdata_valid_o, v.e_rv);
        @(negedge clk);
        #1;
        chk(tag, "after_rvalid", rdata_valid_o, 0);
        chk(tag, "after_err", bus_err_o, 0);
        chk(tag, "after_req", bus_req_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv;

        vecs[0]  = '{MEMOP_SW,  32'h10, 32'hDEADBEEF, 32'h0,        1, 32'h10, 4'b1111, 32'hDEADBEEF, 1'b1, 32'h0,        1'b0};
        vecs[1]  = '{MEMOP_SB,  32'h13, 32'h000000A5, 32'h0,        0, 32'h10, 4'b1000, 32'hA5A5A5A5, 1'b1, 32'h0,        1'b0};
        vecs[2]  = '{MEMOP_LB,  32'h21, 32'h0,        32'h123480FF, 0, 32'h20, 4'b1111, 32'h0,        1'b0, 32'hFFFFFF80, 1'b1};
        vecs[3]  = '{MEMOP_LBU, 32'h21, 32'h0,        32'h123480FF, 0, 32'h20, 4'b1111, 32'h0,        1'b0, 32'h00000080, 1'b1};
        vecs[4]  = '{MEMOP_LH,  32'h22, 32'h0,        32'h80010000, 0, 32'h20, 4'b1111, 32'h0,        1'b0, 32'hFFFF8001, 1'b1};
        vecs[5]  = '{MEMOP_LHU, 32'h22, 32'h0,        32'h80010000, 0, 32'h20, 4'b1111, 32'h0,        1'b0, 32'h00008001, 1'b1};
        vecs[6]  = '{MEMOP_LW,  32'h04, 32'h0,        32'hCAFEF00D, 3, 32'h04, 4'b1111, 32'h0,        1'b0, 32'hCAFEF00D, 1'b1};
        vecs[7]  = '{MEMOP_SH,  32'h16, 32'h1234BEEF, 32'h0,        2, 32'h14, 4'b1100, 32'hBEEFBEEF, 1'b1, 32'h0,        1'b0};
        vecs[8]  = '{MEMOP_SH,  32'h08, 32'h1234BEEF, 32'h0,        0, 32'h08, 4'b0011, 32'hBEEFBEEF, 1'b1, 32'h0,        1'b0};
        vecs[9]  = '{MEMOP_LB,  32'h23, 32'h0,        32'h7F000000, 0, 32'h20, 4'b1111, 32'h0,        1'b0, 32'h0000007F, 1'b1};
        vecs[10] = '{MEMOP_LH,  32'h23, 32'h0,        32'h80010000, 1, 32'h20, 4'b1111, 32'h0,        1'b0, 32'hFFFF8001, 1'b1};
        vecs[11] = '{MEMOP_SB,  32'h00, 32'h1111115A, 32'h0,        0, 32'h00, 4'b0001, 32'h5A5A5A5A, 1'b1, 32'h0,        1'b0};
        vecs[12] = '{MEMOP_LBU, 32'h20, 32'h0,        32'h123480FF, 0, 32'h20, 4'b1111, 32'h0,        1'b0, 32'h000000FF, 1'b1};
        vecs[13] = '{MEMOP_SB,  32'h12, 32'h00000077, 32'h0,        0, 32'h10, 4'b0100, 32'h77777777, 1'b1, 32'h0,        1'b0};
        vecs[14] = '{MEMOP_SW,  32'h1F, 32'h01020304, 32'h0,        0, 32'h1C, 4'b1111, 32'h01020304, 1'b1, 32'h0,        1'b0};

        reset       = 1'b1;
        op_valid_i  = 1'b0;
        op_i        = 3'd0;
        addr_i      = 32'h0;
        wdata_i     = 32'h0;
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset", "stall", stall_o, 0);
        chk("reset", "bus_req", bus_req_o, 0);
        chk("reset", "bus_we", bus_we_o, 0);
        chk("reset", "bus_addr", bus_addr_o, 0);
        chk("reset", "bus_be", {28'h0, bus_be_o}, 0);
        chk("reset", "bus_wdata", bus_wdata_o, 0);
        chk("reset", "rdata", rdata_o, 0);
        chk("reset", "rvalid", rdata_valid_o, 0);
        chk("reset", "bus_err", bus_err_o, 0);
        chk("reset", "exc", {30'h0, exc_adel_o, exc_ades_o}, 0);

        // Stray ack while idle must not start anything.
        @(negedge clk);
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        bus_ack_i   = 1'b0;
        #1;
        chk("idle_ack", "rvalid", rdata_valid_o, 0);
        chk("idle_ack", "bus_req", bus_req_o, 0);

        for (int i = 0; i < NV; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i], 1'b0, 1'b1);
        end

        tv = '{MEMOP_LW, 32'h30, 32'h0, 32'h12345678, TO, 32'h30, 4'b1111, 32'h0, 1'b0, 32'h0, 1'b0};
        run_op("timeout", tv, 1'b1, 1'b0);

        tv = '{MEMOP_LW, 32'h34, 32'h0, 32'h5555AAAA, TO - 1, 32'h34, 4'b1111, 32'h0, 1'b0, 32'h5555AAAA, 1'b1};
        run_op("ack_last", tv, 1'b0, 1'b1);

        tv = '{MEMOP_SW, 32'h38, 32'hA1B2C3D4, 32'h0, TO, 32'h38, 4'b1111, 32'hA1B2C3D4, 1'b1, 32'h0, 1'b0};
        run_op("timeout_sw", tv, 1'b1, 1'b1);

        // Reset while in REQ, with an ack arriving during and after reset.
        @(negedge clk);
        op_valid_i = 1'b1;
        op_i       = MEMOP_LW;
        addr_i     = 32'h40;
        @(negedge clk);
        op_valid_i = 1'b0;
        #1;
        chk("rst_req", "req_before", bus_req_o, 1);
        @(negedge clk);
        reset       = 1'b1;
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h87654321;
        @(negedge clk);
        #1;
        chk("rst_req", "req_after", bus_req_o, 0);
        chk("rst_req", "stall_after", stall_o, 0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_req", "late_rvalid", rdata_valid_o, 0);
        chk("rst_req", "late_req", bus_req_o, 0);
        bus_ack_i = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_req", "late_rvalid2", rdata_valid_o, 0);
        chk("rst_req", "late_rdata", rdata_o, 0);

        run_op("recover", vecs[2], 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
